// File: rtl/load_store_unit.sv
// Load/store unit: decodes core memory ops into a single-beat 32-bit bus access
// with byte enables, lane replication, load extension and a bus timeout.
module load_store_unit #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned TIMEOUT    = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  MemEn,
    input  logic                  MemRW,
    input  logic [2:0]            Funct3,
    input  logic [DATA_WIDTH-1:0] Addr,
    input  logic [DATA_WIDTH-1:0] WData,
    output logic [DATA_WIDTH-1:0] RData,
    output logic                  Stall,
    output logic                  Fault,
    output logic                  BusErr,
    output logic                  bus_req,
    output logic                  bus_we,
    output logic [DATA_WIDTH-1:0] bus_addr,
    output logic [3:0]            bus_be,
    output logic [DATA_WIDTH-1:0] bus_wdata,
    input  logic [DATA_WIDTH-1:0] bus_rdata,
    input  logic                  bus_ack
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e                  state_q, state_d;
    logic                    bus_req_q, bus_req_d;
    logic                    bus_we_q, bus_we_d;
    logic [DATA_WIDTH-1:0]   bus_addr_q, bus_addr_d;
    logic [3:0]              bus_be_q, bus_be_d;
    logic [DATA_WIDTH-1:0]   bus_wdata_q, bus_wdata_d;
    logic [2:0]              f3_q, f3_d;
    logic [1:0]              off_q, off_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    err_q, err_d;
    logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;

    logic                    illegal_c;
    logic [3:0]              be_c;
    logic [DATA_WIDTH-1:0]   wdata_c;
    logic [7:0]              byte_c;
    logic [15:0]             half_c;
    logic [DATA_WIDTH-1:0]   load_c;

    // Access decode: legality, byte enables and lane-replicated store data
    always_comb begin
        illegal_c = 1'b0;
        case (Funct3)
            3'b011, 3'b110, 3'b111: illegal_c = 1'b1;
            default:                illegal_c = 1'b0;
        endcase
        if (MemRW && Funct3[2]) illegal_c = 1'b1;
        if (Funct3[1:0] == 2'b01 && Addr[0]) illegal_c = 1'b1;
        if (Funct3[1:0] == 2'b10 && Addr[1:0] != 2'b00) illegal_c = 1'b1;

        case (Funct3[1:0])
            2'b00:   be_c = 4'b0001 << Addr[1:0];
            2'b01:   be_c = 4'b0011 << Addr[1:0];
            default: be_c = 4'b1111;
        endcase

        case (Funct3[1:0])
            2'b00:   wdata_c = {4{WData[7:0]}};
            2'b01:   wdata_c = {2{WData[15:0]}};
            default: wdata_c = WData;
        endcase
    end

    // Lane select and extension of captured read data
    always_comb begin
        byte_c = rdata_q[8*off_q +: 8];
        half_c = off_q[1] ? rdata_q[31:16] : rdata_q[15:0];
        case (f3_q)
            3'b000:  load_c = {{(DATA_WIDTH-8){byte_c[7]}}, byte_c};
            3'b100:  load_c = {{(DATA_WIDTH-8){1'b0}}, byte_c};
            3'b001:  load_c = {{(DATA_WIDTH-16){half_c[15]}}, half_c};
            3'b101:  load_c = {{(DATA_WIDTH-16){1'b0}}, half_c};
            default: load_c = rdata_q;
        endcase
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            bus_req_q   <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= '0;
            bus_be_q    <= '0;
            bus_wdata_q <= '0;
            f3_q        <= '0;
            off_q       <= '0;
            cnt_q       <= '0;
            err_q       <= 1'b0;
            rdata_q     <= '0;
        end else begin
            state_q     <= state_d;
            bus_req_q   <= bus_req_d;
            bus_we_q    <= bus_we_d;
            bus_addr_q  <= bus_addr_d;
            bus_be_q    <= bus_be_d;
            bus_wdata_q <= bus_wdata_d;
            f3_q        <= f3_d;
            off_q       <= off_d;
            cnt_q       <= cnt_d;
            err_q       <= err_d;
            rdata_q     <= rdata_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d     = state_q;
        bus_req_d   = bus_req_q;
        bus_we_d    = bus_we_q;
        bus_addr_d  = bus_addr_q;
        bus_be_d    = bus_be_q;
        bus_wdata_d = bus_wdata_q;
        f3_d        = f3_q;
        off_d       = off_q;
        cnt_d       = cnt_q;
        err_d       = err_q;
        rdata_d     = rdata_q;

        case (state_q)
            IDLE: begin
                if (MemEn && !illegal_c) begin
                    state_d     = BUSY;
                    bus_req_d   = 1'b1;
                    bus_we_d    = MemRW;
                    bus_addr_d  = {Addr[DATA_WIDTH-1:2], 2'b00};
                    bus_be_d    = be_c;
                    bus_wdata_d = wdata_c;
                    f3_d        = Funct3;
                    off_d       = Addr[1:0];
                    cnt_d       = '0;
                    err_d       = 1'b0;
                end
            end
            BUSY: begin
                // An ack on the terminal count still completes cleanly
                if (bus_ack) begin
                    state_d   = DONE;
                    bus_req_d = 1'b0;
                    if (!bus_we_q) rdata_d = bus_rdata;
                end else if (cnt_q == CNT_LAST) begin
                    state_d   = DONE;
                    bus_req_d = 1'b0;
                    err_d     = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
            default: begin
                state_d   = IDLE;
                bus_req_d = 1'b0;
            end
        endcase
    end

    // Core-facing status is combinational from state so faults and stalls act in the same cycle
    always_comb begin
        Stall     = ((state_q == IDLE) && MemEn && !illegal_c) || (state_q == BUSY);
        Fault     = (state_q == IDLE) && MemEn && illegal_c && !rst;
        BusErr    = (state_q == DONE) && err_q;
        RData     = ((state_q == DONE) && !err_q && !bus_we_q) ? load_c : '0;
        bus_req   = bus_req_q;
        bus_we    = bus_we_q;
        bus_addr  = bus_addr_q;
        bus_be    = bus_be_q;
        bus_wdata = bus_wdata_q;
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed vector table, randomized
// accesses against an arithmetic reference model, and reset corner sequences.
module tb_load_store_unit;

    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        MemEn, MemRW;
    logic [2:0]  Funct3;
    logic [31:0] Addr, WData, RData;
    logic        Stall, Fault, BusErr;
    logic        bus_req, bus_we;
    logic [31:0] bus_addr, bus_wdata, bus_rdata;
    logic [3:0]  bus_be;
    logic        bus_ack;

    int checks = 0;
    int errors = 0;

    load_store_unit #(.DATA_WIDTH(32), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .MemEn(MemEn), .MemRW(MemRW), .Funct3(Funct3), .Addr(Addr), .WData(WData),
        .RData(RData), .Stall(Stall), .Fault(Fault), .BusErr(BusErr),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_be(bus_be),
        .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .bus_ack(bus_ack)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rw;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          dly;
        logic        xfault;
        logic [3:0]  xbe;
        logic [31:0] xwd;
        logic [31:0] xr;
        logic        xerr;
        int          xreq;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model: access width in bytes and its low-bit mask
    function automatic int nbytes(input logic [2:0] f3);
        return 1 << f3[1:0];
    endfunction

    function automatic logic [31:0] lane_mask(input int n);
        return (n == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * n)) - 32'd1);
    endfunction

    function automatic logic m_illegal(input logic rw, input logic [2:0] f3, input logic [31:0] a);
        int n;
        n = nbytes(f3);
        if (f3[1:0] == 2'b11) return 1'b1;
        if (f3[2] && (rw || f3[1:0] == 2'b10)) return 1'b1;
        return (a % n) != 0;
    endfunction

    function automatic logic [3:0] m_be(input logic [2:0] f3, input logic [31:0] a);
        int n;
        n = nbytes(f3);
        return 4'(((1 << n) - 1) << (a % 4));
    endfunction

    function automatic logic [31:0] m_wd(input logic [2:0] f3, input logic [31:0] wd);
        logic [31:0] m;
        m = lane_mask(nbytes(f3));
        return (wd & m) * (32'hFFFF_FFFF / m);
    endfunction

    function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] rd);
        int n;
        logic [31:0] m, v;
        n = nbytes(f3);
        m = lane_mask(n);
        v = (rd >> (8 * (a % 4))) & m;
        if (!f3[2] && n < 4 && ((v & ~(m >> 1)) != 0)) v = v | ~m;
        return v;
    endfunction

    // One complete access from IDLE through DONE, checked cycle by cycle
    task automatic run_access(input vec_t v, input string tag);
        int reqs;
        MemEn = 1'b1; MemRW = v.rw; Funct3 = v.f3; Addr = v.addr; WData = v.wdata;
        bus_rdata = v.rdata; bus_ack = 1'b0;
        #1;
        chk({tag, " fault"}, 32'(Fault), 32'(v.xfault));
        chk({tag, " stall_idle"}, 32'(Stall), 32'(!v.xfault));
        if (v.xfault) begin
            chk({tag, " rdata_fault"}, RData, 32'h0);
            @(posedge clk); #1;
            MemEn = 1'b0; #1;
            chk({tag, " req_fault"}, 32'(bus_req), 32'h0);
            chk({tag, " stall_after_fault"}, 32'(Stall), 32'h0);
            return;
        end
        @(posedge clk); #1;
        reqs = 0;
        for (int k = 0; k < TO; k++) begin
            bus_ack = (k == v.dly); #1;
            if (bus_req) reqs++;
            chk({tag, " stall_busy"}, 32'(Stall), 32'h1);
            if (k == 0) begin
                chk({tag, " addr"}, bus_addr, v.addr & 32'hFFFF_FFFC);
                chk({tag, " we"}, 32'(bus_we), 32'(v.rw));
                chk({tag, " be"}, 32'(bus_be), 32'(v.xbe));
                chk({tag, " wdata"}, bus_wdata, v.xwd);
                chk({tag, " rdata_busy"}, RData, 32'h0);
            end
            if (k == v.dly || k == TO - 1) break;
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        bus_ack = 1'b0; MemEn = 1'b0; #1;
        if (bus_req) reqs++;
        chk({tag, " rdata_done"}, RData, v.xr);
        chk({tag, " buserr"}, 32'(BusErr), 32'(v.xerr));
        chk({tag, " stall_done"}, 32'(Stall), 32'h0);
        chk({tag, " req_cycles"}, 32'(reqs), 32'(v.xreq));
        @(posedge clk); #1;
        chk({tag, " buserr_idle"}, 32'(BusErr), 32'h0);
    endtask

    vec_t tbl[$];
    vec_t v;

    initial begin
        rst = 1'b1; MemEn = 1'b0; MemRW = 1'b0; Funct3 = 3'b010; Addr = '0; WData = '0;
        bus_rdata = '0; bus_ack = 1'b0;

        //            rw    f3      addr          wdata         rdata         dly fault be       xwd           xr            err req
        tbl.push_back('{1'b0, 3'b010, 32'h0000_0100, 32'h0,        32'hDEAD_BEEF, 0, 1'b0, 4'b1111, 32'h0,        32'hDEAD_BEEF, 1'b0, 1});
        tbl.push_back('{1'b0, 3'b000, 32'h0000_0103, 32'h0,        32'h80FF_1234, 0, 1'b0, 4'b1000, 32'h0,        32'hFFFF_FF80, 1'b0, 1});
        tbl.push_back('{1'b0, 3'b100, 32'h0000_0103, 32'h0,        32'h80FF_1234, 0, 1'b0, 4'b1000, 32'h0,        32'h0000_0080, 1'b0, 1});
        tbl.push_back('{1'b1, 3'b001, 32'h0000_0202, 32'h0000_ABCD, 32'h1111_1111, 2, 1'b0, 4'b1100, 32'hABCD_ABCD, 32'h0,        1'b0, 3});
        tbl.push_back('{1'b0, 3'b010, 32'h0000_0101, 32'h0,        32'h0,        0, 1'b1, 4'b0000, 32'h0,        32'h0,        1'b0, 0});
        tbl.push_back('{1'b0, 3'b010, 32'h0000_0200, 32'h0,        32'h5555_5555, 99, 1'b0, 4'b1111, 32'h0,       32'h0,        1'b1, 16});
        tbl.push_back('{1'b0, 3'b010, 32'h0000_0200, 32'h0,        32'h1234_5678, 15, 1'b0, 4'b1111, 32'h0,       32'h1234_5678, 1'b0, 16});
        tbl.push_back('{1'b0, 3'b001, 32'h0000_0102, 32'h0,        32'h80FF_1234, 0, 1'b0, 4'b1100, 32'h0,        32'hFFFF_80FF, 1'b0, 1});
        tbl.push_back('{1'b0, 3'b101, 32'h0000_0102, 32'h0,        32'h80FF_1234, 0, 1'b0, 4'b1100, 32'h0,        32'h0000_80FF, 1'b0, 1});
        tbl.push_back('{1'b0, 3'b011, 32'h0000_0000, 32'h0,        32'h0,        0, 1'b1, 4'b0000, 32'h0,        32'h0,        1'b0, 0});
        tbl.push_back('{1'b1, 3'b100, 32'h0000_0000, 32'h0,        32'h0,        0, 1'b1, 4'b0000, 32'h0,        32'h0,        1'b0, 0});
        tbl.push_back('{1'b0, 3'b001, 32'h0000_0101, 32'h0,        32'h0,        0, 1'b1, 4'b0000, 32'h0,        32'h0,        1'b0, 0});
        tbl.push_back('{1'b1, 3'b000, 32'h0000_0101, 32'h1234_56A5, 32'h0,       1, 1'b0, 4'b0010, 32'hA5A5_A5A5, 32'h0,        1'b0, 2});
        tbl.push_back('{1'b1, 3'b010, 32'h0000_0300, 32'hCAFE_F00D, 32'h0,       99, 1'b0, 4'b1111, 32'hCAFE_F00D, 32'h0,       1'b1, 16});

        // Reset values, including status during reset with core requests present
        repeat (2) @(posedge clk);
        #1;
        chk("rst bus_req", 32'(bus_req), 32'h0);
        chk("rst bus_we", 32'(bus_we), 32'h0);
        chk("rst bus_be", 32'(bus_be), 32'h0);
        chk("rst bus_addr", bus_addr, 32'h0);
        chk("rst bus_wdata", bus_wdata, 32'h0);
        chk("rst rdata", RData, 32'h0);
        chk("rst buserr", 32'(BusErr), 32'h0);
        chk("rst stall_idle", 32'(Stall), 32'h0);
        MemEn = 1'b1; Funct3 = 3'b010; Addr = 32'h101; #1;
        chk("rst fault_masked", 32'(Fault), 32'h0);
        Addr = 32'h100; #1;
        chk("rst stall_follows", 32'(Stall), 32'h1);
        MemEn = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;

        // Stray ack while idle has no effect
        bus_ack = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("idle_ack bus_req", 32'(bus_req), 32'h0);
        chk("idle_ack stall", 32'(Stall), 32'h0);
        chk("idle_ack buserr", 32'(BusErr), 32'h0);
        bus_ack = 1'b0;

        for (int i = 0; i < tbl.size(); i++) run_access(tbl[i], $sformatf("vec%0d", i));

        // Randomized accesses against the reference model
        for (int i = 0; i < 150; i++) begin
            v.rw    = 1'($urandom_range(0, 1));
            v.f3    = 3'($urandom_range(0, 7));
            v.addr  = $urandom;
            v.wdata = $urandom;
            v.rdata = $urandom;
            v.dly   = $urandom_range(0, 20);
            v.xfault = m_illegal(v.rw, v.f3, v.addr);
            v.xbe   = m_be(v.f3, v.addr);
            v.xwd   = m_wd(v.f3, v.wdata);
            v.xerr  = (v.dly >= TO);
            v.xreq  = v.xerr ? TO : v.dly + 1;
            v.xr    = (v.rw || v.xerr) ? 32'h0 : m_load(v.f3, v.addr, v.rdata);
            run_access(v, $sformatf("rnd%0d", i));
        end

        // Reset in the middle of a bus wait aborts it; late ack afterwards is ignored
        MemEn = 1'b1; MemRW = 1'b0; Funct3 = 3'b010; Addr = 32'h400; bus_ack = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("abort req_before", 32'(bus_req), 32'h1);
        rst = 1'b1; #1;
        chk("abort req_now", 32'(bus_req), 32'h0);
        chk("abort stall_rst", 32'(Stall), 32'h1);
        chk("abort rdata", RData, 32'h0);
        chk("abort buserr", 32'(BusErr), 32'h0);
        MemEn = 1'b0; #1;
        chk("abort stall_memen0", 32'(Stall), 32'h0);
        @(posedge clk); #1;
        rst = 1'b0; bus_ack = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            chk($sformatf("late_ack req%0d", k), 32'(bus_req), 32'h0);
            chk($sformatf("late_ack stall%0d", k), 32'(Stall), 32'h0);
            chk($sformatf("late_ack buserr%0d", k), 32'(BusErr), 32'h0);
            chk($sformatf("late_ack rdata%0d", k), RData, 32'h0);
        end
        MemEn = 1'b1; #1;
        chk("late_ack stall_follows", 32'(Stall), 32'h1);
        MemEn = 1'b0; bus_ack = 1'b0; #1;
        @(posedge clk); #1;
        chk("final idle req", 32'(bus_req), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
